cnt60_input_ctrl: RTL and testbench

- Upstream front-end for the cnt60 time counter.
- Generates the periodic count-enable tick CEN from the system clock, and the single-cycle INC/DEC adjust pulses from raw mechanical push-buttons.
- Raw inputs are synchronised and debounced, and every output is registered, so the counter sees clean one-cycle strobes.
- Outputs connect directly to cnt60 CEN/INC/DEC.

---
 rtl/cnt60_input_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_cnt60_input_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt60_input_ctrl.sv
// ---------------------------------------------------------------------------
// cnt60_input_ctrl
//
// Front-end for the cnt60 time counter. Derives the periodic count-enable
// tick (CEN) from the system clock and turns two raw mechanical push-buttons
// into clean single-cycle INC / DEC adjust strobes. All three raw inputs are
// synchronised with a two-flop chain; the buttons are additionally debounced.
// Every output is a flop, and at most one output is high in any cycle.
//
// Optional feature (compile-time macro CNT60_AUTOREPEAT_EN):
//   defined   - a button held on its own emits a further pulse REP_DLY cycles
//               after its press pulse, then one every REP_PER cycles until it
//               is released or the other button is also held.
//   undefined - exactly one pulse per debounced press; REP_DLY / REP_PER are
//               only range-checked.
//
// Parameters:
//   DIV     - clock cycles per CEN tick (>= 2)
//   DEB_CYC - consecutive stable cycles needed to accept a level change (>= 1)
//   REP_DLY - cycles from the press pulse to the first repeat pulse
//   REP_PER - cycles between subsequent repeat pulses
//
// Ports:
//   clk         in  system clock, all logic on the rising edge
//   rst         in  synchronous reset, active-high
//   run_raw     in  asynchronous run switch, 1 = time advances
//   btn_inc_raw in  asynchronous bouncing increment button, active-high
//   btn_dec_raw in  asynchronous bouncing decrement button, active-high
//   CEN         out one-cycle count-enable tick
//   INC         out one-cycle increment strobe
//   DEC         out one-cycle decrement strobe
// ---------------------------------------------------------------------------
module cnt60_input_ctrl #(
  parameter int DIV     = 50_000_000,
  parameter int DEB_CYC = 500_000,
  parameter int REP_DLY = 25_000_000,
  parameter int REP_PER = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_raw,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic CEN,
  output logic INC,
  output logic DEC
);

  // Counter widths: each counter holds at most its terminal value.
  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DEB_CYC + 1);

  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_M1 = DW'(DEB_CYC - 1);

  // Elaboration-time parameter range checks.
  if (DIV < 2) begin : g_bad_div
    $error("cnt60_input_ctrl: DIV must be at least 2");
  end
  if (DEB_CYC < 1) begin : g_bad_deb
    $error("cnt60_input_ctrl: DEB_CYC must be at least 1");
  end
  if ((REP_DLY < 1) || (REP_PER < 1)) begin : g_bad_rep
    $error("cnt60_input_ctrl: REP_DLY and REP_PER must be at least 1");
  end

  // Synchroniser chain, bit 0 = run, bit 1 = inc, bit 2 = dec.
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;

  // Debounce state, index 0 = inc, index 1 = dec.
  logic [1:0]    r_stable;
  logic [1:0]    r_stable_d;
  logic [DW-1:0] r_deb_cnt [2];

  logic [PW-1:0] r_presc;

  logic          r_cen;
  logic          r_inc;
  logic          r_dec;

  logic          w_run;
  logic [1:0]    w_btn;
  logic          w_any_held;
  logic          w_one_held;
  logic          w_press_inc;
  logic          w_press_dec;
  logic          w_press_any;
  logic          w_tick;
  logic          w_rep_fire;
  logic          w_rep_sel;
  logic          w_inc_nxt;
  logic          w_dec_nxt;

  assign w_run = r_sync2[0];
  assign w_btn = r_sync2[2:1];

  assign w_any_held = r_stable[0] | r_stable[1];
  assign w_one_held = r_stable[0] ^ r_stable[1];

  // A press is a stable rising edge, and only counts while the other button
  // is not stably held; if both rise together neither is accepted.
  assign w_press_inc = r_stable[0] & ~r_stable_d[0] & ~r_stable[1];
  assign w_press_dec = r_stable[1] & ~r_stable_d[1] & ~r_stable[0];
  assign w_press_any = w_press_inc | w_press_dec;

  // Prescaler wrap; only possible while running with no button held.
  assign w_tick = w_run & ~w_any_held & (r_presc == DIV_M1);

  assign w_inc_nxt = w_press_inc | (w_rep_fire & ~w_rep_sel);
  assign w_dec_nxt = w_press_dec | (w_rep_fire &  w_rep_sel);

  // Two-flop synchronisers for the three asynchronous inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {btn_dec_raw, btn_inc_raw, run_raw};
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: a level is accepted after DEB_CYC consecutive
  // mismatching cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable   <= 2'b00;
      r_stable_d <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (w_btn[i] != r_stable[i]) begin
          if (r_deb_cnt[i] == DEB_M1) begin
            r_stable[i]  <= w_btn[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  // CEN prescaler: cleared while any button is held, frozen while stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_any_held) begin
      r_presc <= '0;
    end else if (w_run) begin
      if (r_presc == DIV_M1) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end else begin
      r_presc <= r_presc;
    end
  end

`ifdef CNT60_AUTOREPEAT_EN
  localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [RW-1:0] DLY_M1 = RW'(REP_DLY - 1);
  localparam logic [RW-1:0] PER_M1 = RW'(REP_PER - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_act;
  logic          r_rep_ph;   // 0: waiting out REP_DLY, 1: repeating at REP_PER
  logic          r_rep_sel;  // 0: inc, 1: dec
  logic          w_rep_hold;
  logic          w_rep_term;

  assign w_rep_hold = w_one_held & r_rep_act & r_stable[r_rep_sel];
  assign w_rep_term = (r_rep_cnt == (r_rep_ph ? PER_M1 : DLY_M1));
  assign w_rep_fire = w_rep_hold & ~w_press_any & w_rep_term;
  assign w_rep_sel  = r_rep_sel;

  // Auto-repeat timer: armed by a press pulse, cleared as soon as the
  // pressed button is no longer the only one held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b0;
      r_rep_ph  <= 1'b0;
      r_rep_sel <= 1'b0;
    end else if (!w_one_held) begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b0;
      r_rep_ph  <= 1'b0;
      r_rep_sel <= r_rep_sel;
    end else if (w_press_any) begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b1;
      r_rep_ph  <= 1'b0;
      r_rep_sel <= w_press_dec;
    end else if (w_rep_hold) begin
      if (w_rep_term) begin
        r_rep_cnt <= '0;
        r_rep_ph  <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
        r_rep_ph  <= r_rep_ph;
      end
      r_rep_act <= 1'b1;
      r_rep_sel <= r_rep_sel;
    end else begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b0;
      r_rep_ph  <= 1'b0;
      r_rep_sel <= r_rep_sel;
    end
  end
`else
  assign w_rep_fire = 1'b0;
  assign w_rep_sel  = 1'b0;
`endif

  // Registered outputs; a CEN tick that meets an adjust pulse is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cen <= 1'b0;
      r_inc <= 1'b0;
      r_dec <= 1'b0;
    end else begin
      r_cen <= w_tick & ~w_inc_nxt & ~w_dec_nxt;
      r_inc <= w_inc_nxt;
      r_dec <= w_dec_nxt;
    end
  end

  assign CEN = r_cen;
  assign INC = r_inc;
  assign DEC = r_dec;

endmodule

// File: tb/tb_cnt60_input_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cnt60_input_ctrl (DIV=10, DEB_CYC=4, REP_DLY=20,
// REP_PER=8). Directed scenarios followed by randomized button/run/reset
// activity; every cycle is compared against a behavioural reference model
// that reasons in terms of sampled levels, mismatch streak lengths and the
// elapsed time since a press.
// ---------------------------------------------------------------------------
module tb_cnt60_input_ctrl;

  localparam int DIV  = 10;
  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;
`ifdef CNT60_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_raw = 1'b0;
  logic btn_inc_raw = 1'b0;
  logic btn_dec_raw = 1'b0;
  logic CEN, INC, DEC;

  cnt60_input_ctrl #(
    .DIV(DIV), .DEB_CYC(DEB), .REP_DLY(RDLY), .REP_PER(RPER)
  ) dut (
    .clk(clk), .rst(rst), .run_raw(run_raw),
    .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .CEN(CEN), .INC(INC), .DEC(DEC)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit o_cen, o_inc, o_dec;

  // Reference model state
  bit [2:0] m_s1, m_s2;        // input delay line {dec, inc, run}
  bit [1:0] m_stab;            // accepted button levels {dec, inc}
  int       m_streak [2];      // consecutive cycles sync differs from level
  int       m_rise_at [2];     // cycle at which the level last went high
  int       m_pc;              // run cycles since the prescaler last restarted
  bit       m_rep_ok [2];
  int       m_t0 [2];          // cycle of the press pulse
  bit       e_cen, e_inc, e_dec;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit [2:0] raw);
    bit [1:0] old_stab;
    bit [1:0] btn_s;
    bit       run_s, one, tk;
    bit       p [2];
    bit       rp [2];
    int       d;
    if (r) begin
      m_s1 = 3'b000; m_s2 = 3'b000; m_stab = 2'b00; m_pc = 0;
      for (int b = 0; b < 2; b++) begin
        m_streak[b] = 0; m_rise_at[b] = -10; m_rep_ok[b] = 1'b0; m_t0[b] = 0;
      end
      e_cen = 1'b0; e_inc = 1'b0; e_dec = 1'b0;
    end else begin
      old_stab = m_stab;
      run_s    = m_s2[0];
      btn_s    = m_s2[2:1];
      one      = old_stab[0] ^ old_stab[1];
      for (int b = 0; b < 2; b++) begin
        // press pulse the cycle after the level rose, unless the other is held
        p[b]  = (m_rise_at[b] == cyc - 1) && !old_stab[1-b];
        rp[b] = 1'b0;
        if (!(one && old_stab[b])) begin
          m_rep_ok[b] = 1'b0;
        end else if (p[b]) begin
          m_rep_ok[b] = 1'b1;
          m_t0[b] = cyc;
        end else if (m_rep_ok[b] && AR) begin
          d = cyc - m_t0[b];
          rp[b] = (d == RDLY) || ((d > RDLY) && ((d - RDLY) % RPER == 0));
        end
      end
      e_inc = p[0] | rp[0];
      e_dec = p[1] | rp[1];
      tk = 1'b0;
      if (old_stab != 2'b00) begin
        m_pc = 0;
      end else if (run_s) begin
        m_pc = (m_pc + 1) % DIV;
        tk = (m_pc == 0);
      end
      e_cen = tk && !e_inc && !e_dec;
      for (int b = 0; b < 2; b++) begin
        if (btn_s[b] != m_stab[b]) begin
          m_streak[b]++;
          if (m_streak[b] == DEB) begin
            m_stab[b] = btn_s[b];
            m_streak[b] = 0;
            if (btn_s[b]) m_rise_at[b] = cyc;
          end
        end else begin
          m_streak[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  // Apply one cycle of inputs, advance the model and compare all outputs.
  task automatic tick(input bit r, input bit rn, input bit bi, input bit bd);
    rst = r; run_raw = rn; btn_inc_raw = bi; btn_dec_raw = bd;
    @(posedge clk);
    model_edge(r, {bd, bi, rn});
    #1;
    o_cen = CEN; o_inc = INC; o_dec = DEC;
    check_val("cen", int'(o_cen), int'(e_cen));
    check_val("inc", int'(o_inc), int'(e_inc));
    check_val("dec", int'(o_dec), int'(e_dec));
    check_val("excl", $onehot0({o_cen, o_inc, o_dec}) ? 1 : 0, 1);
    cyc++;
  endtask

  initial begin
    int n, first, last, np, nc;
    bit lv_run, lv_inc, lv_dec, r, raw_inc, raw_dec;
    int bn_inc, bn_dec;
    bit pat [5];

    // Reset with every raw input high, then one INC from a held button.
    repeat (3) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      check_val("rst_out", int'({o_cen, o_inc, o_dec}), 0);
    end
    n = 0; first = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      if (o_inc) begin n++; if (first < 0) first = k; end
    end
    check_val("rst_inc_cnt", n, 1);
    check_val("rst_inc_lat", first, DEB + 3);
    repeat (12) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Free-running CEN, then stop and resume.
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0; first = -1; last = -1;
    for (int k = 1; k <= 95; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      if (o_cen) begin
        if (last >= 0) check_val("cen_period", k - last, DIV);
        else first = k;
        n++; last = k;
      end
    end
    check_val("cen_first", first, DIV + 2);
    check_val("cen_cnt", n, (95 - (DIV + 2)) / DIV + 1);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (o_cen) n++;
    end
    check_val("cen_stopped", n, 0);
    // 93 run cycles before the stop plus 2 still in the synchroniser
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      if (o_cen && first < 0) first = k;
    end
    check_val("cen_resume", first, 2 + DIV - ((93 % DIV) + 2));

    // Bouncing increment press.
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
    n = 0; first = -1;
    for (int k = 1; k <= 30; k++) begin
      tick(1'b0, 1'b0, (k <= 5) ? pat[k-1] : 1'b1, 1'b0);
      if (o_inc) begin n++; if (first < 0) first = k; end
    end
    check_val("bounce_cnt", n, 1);
    check_val("bounce_lat", first, 5 + DEB + 2);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Both held, dec released first, then inc released.
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
    np = 0; nc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1'b0, 1'b1, 1'b1, (k <= 15));
      if (o_inc || o_dec) np++;
      if (o_cen) nc++;
    end
    check_val("both_cen", nc, 0);
    first = -1;
    for (int j = 1; j <= 25; j++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      if (o_inc || o_dec) np++;
      if (o_cen && first < 0) first = j;
    end
    check_val("both_pulses", np, 0);
    check_val("both_rel_cen", first, 2 + DEB + DIV);

    // Press while running: pulse and CEN never overlap, period restarts.
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) tick(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      if (o_inc) n++;
    end
    first = -1;
    for (int j = 1; j <= 25; j++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      if (o_inc) n++;
      if (o_cen && first < 0) first = j;
    end
    check_val("run_inc_cnt", n, 1);
    check_val("run_rel_cen", first, 2 + DEB + DIV);

    // Long decrement hold: auto-repeat when enabled, single pulse otherwise.
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0; first = -1;
    for (int k = 1; k <= 80; k++) begin
      tick(1'b0, 1'b0, 1'b0, (k <= 60));
      if (o_dec) begin n++; if (first < 0) first = k; end
    end
    check_val("hold_dec_first", first, DEB + 3);
    check_val("hold_dec_cnt", n, AR ? 6 : 1);

    // Randomized activity with occasional bounces and resets.
    lv_run = 1'b0; lv_inc = 1'b0; lv_dec = 1'b0; bn_inc = 0; bn_dec = 0;
    for (int t = 0; t < 3000; t++) begin
      r = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) lv_run = ~lv_run;
      if ($urandom_range(0, 44) == 0) begin lv_inc = ~lv_inc; bn_inc = $urandom_range(0, 6); end
      if ($urandom_range(0, 44) == 0) begin lv_dec = ~lv_dec; bn_dec = $urandom_range(0, 6); end
      raw_inc = lv_inc ^ ((bn_inc > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      raw_dec = lv_dec ^ ((bn_dec > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (bn_inc > 0) bn_inc--;
      if (bn_dec > 0) bn_dec--;
      tick(r, lv_run, raw_inc, raw_dec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
